ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
// - Parametrised PS/2 keyboard receiver: synchronises and filters PS2 clock/data, deframes 11-bit frames,
//   decodes E0/F0 prefixes into key events, tracks shift, buffers events in a FIFO, drives hex 7-seg history.
// - Sits between the board PS/2 pins and the top level. Adds error flags, timeout, FIFO back-pressure and
//   N-digit display to the single-code receiver generation.
// PARAMETERS
// - CLK_HZ          50_000_000  system clock frequency; sets timeout count
// - FIFO_DEPTH      8           event FIFO entries; power of 2, >=2
// - NUM_DIGITS      6           7-seg digits; even, 2..8; shows last NUM_DIGITS/2 make codes
// - TIMEOUT_US      200         max gap between PS2 clock falling edges inside a frame
// - FILTER_LEN      8           consecutive equal samples needed to accept a PS2 clock level
// - SEG_ACTIVE_LOW  1           1: segment on = 0
// PORTS
// - clk          in   1                       system clock
// - rst          in   1                       reset; synchronous, active-high
// - PS2Clk       in   1                       PS/2 clock pin (async)
// - datai        in   1                       PS/2 data pin (async)
// - key_valid    out  1                       FIFO head valid (FIFO not empty)
// - key_ready    in   1                       consumer pops head when key_valid&&key_ready
// - key_code     out  8                       head scancode (prefixes stripped)
// - key_ext      out  1                       head had E0 prefix
// - key_break    out  1                       head had F0 prefix (key release)
// - fifo_count   out  $clog2(FIFO_DEPTH+1)    occupied entries
// - shift        out  1                       left or right shift held
// - err_parity   out  1                       1-cycle pulse: parity failure
// - err_frame    out  1                       1-cycle pulse: bad stop bit or timeout
// - overflow     out  1                       sticky: event dropped on full FIFO; cleared by rst only
// - seg          out  NUM_DIGITS*7            digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
// - Reset: FSM IDLE, FIFO empty, prefix/shift flags 0, history blank; all outputs 0 except seg = all segs off.
//   rst mid-frame abandons the frame, no error pulse.
// - Input: 2-FF sync on both pins; filtered clock changes only after FILTER_LEN equal samples;
//   filtered falling edge samples synced data.
// - Frame FSM: IDLE -(edge,data=0)-> DATA; IDLE edge with data=1 ignored. DATA: 8 bits LSB first -> PARITY
//   -> STOP. At STOP: data=1 and odd parity (^{byte,par}==1) -> byte_valid; parity bad -> err_parity;
//   stop=0 -> err_frame (frame check wins if both). Always return to IDLE.
// - Timeout: counter cleared on every filtered edge; in non-IDLE, reaching CLK_HZ/1e6*TIMEOUT_US -> err_frame, IDLE.
// - Decoder: E0 sets ext, F0 sets brk, other byte -> event {ext,brk,code} (registered, next cycle), flags cleared.
//   Error pulse clears ext/brk. E1, AA, FA etc. are ordinary codes.
// - Shift: non-ext 0x12 / 0x59 make sets L/R bit, break clears it; shift = L|R, updates with event. Shift events still queued.
// - FIFO: first-word-fall-through; event visible on key_* one cycle after event register.
//   Push+pop same cycle when full: both occur, count unchanged. Push when full, no pop: drop event, overflow=1.
//   Pop when empty: ignored.
// - Display: each make event (brk=0, ext ignored) shifts history up one byte; newest code in digits [1:0] (digit 1 = high nibble).
//   Invalid history slots blank. Break events leave display unchanged. Hex->7seg standard, inverted if SEG_ACTIVE_LOW.
// STRUCTURE
// - ps2_pkg: frame state enum; SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59;
//   ps2_event_t packed struct {ext,brk,code[7:0]}; function hex_to_seg(logic[3:0]).
// - Sub-module ps2_frame_rx: sync, filter, edge detect, frame FSM, timeout; outputs byte, byte_valid, err pulses.
// - Prefix decode, shift tracking, FIFO and display history inline.
// TESTING
// - Frame 0x1C, par=0, stop=1 -> key_valid, code 1C ext0 brk0; seg digits[1:0] = "1C"; fifo_count 1->0 on pop.
// - Bytes E0,F0,75 -> exactly one event: code 75 ext1 brk1; display unchanged; no error pulses.
// - 12 -> shift=1; 59 -> shift=1; F0,12 -> shift=1; F0,59 -> shift=0; E0,12 -> shift unaffected.
// - Frame 0x1C with par=1 -> err_parity high 1 cycle, no event, fifo_count=0; stop=0 frame -> err_frame.
// - key_ready=0, FIFO_DEPTH+1 makes (codes 01..09 for depth 8) -> count=8, overflow=1; pops return 01..08 in order.
// - 5 data bits then silence > TIMEOUT_US -> err_frame, then frame 0x29 decoded cleanly; rst mid-frame -> no event.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver.
// Frame states, scancode constants, event bundle, hex decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, clock glitch filter,
// 11-bit deframer with parity/stop checks and inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       err_parity_o,
  output logic       err_frame_o
);

  localparam int TO_MAX = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TOW    = $clog2(TO_MAX + 1);
  localparam int FW     = $clog2(FILTER_LEN + 1);

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          flt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          flt_chg;
  logic          fall;

  frame_state_e   state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     sh_q;
  logic           par_q;
  logic [TOW-1:0] to_cnt_q;
  logic [7:0]     data_q;
  logic           dv_q, ep_q, ef_q;

  assign flt_chg = (clk_s2_q != flt_q) &&
                   (flt_cnt_q == FW'(FILTER_LEN - 1));
  assign fall    = flt_chg && flt_q;

  // Two-flop sync on both pins; clock level accepted after a stable run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat_i;
      dat_s2_q <= dat_s1_q;
      if (clk_s2_q == flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_chg) begin
        flt_q     <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  // Frame FSM sampling data on filtered falling edges, plus timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      ep_q      <= 1'b0;
      ef_q      <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      ep_q <= 1'b0;
      ef_q <= 1'b0;
      if (flt_chg || state_q == ST_IDLE) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TOW'(TO_MAX - 1)) begin
        to_cnt_q <= '0;
        ef_q     <= 1'b1;
        state_q  <= ST_IDLE;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (fall) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            sh_q <= {dat_s2_q, sh_q[7:1]};
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          ST_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (!dat_s2_q) begin
              ef_q <= 1'b1;
            end else if (^{sh_q, par_q}) begin
              dv_q   <= 1'b1;
              data_q <= sh_q;
            end else begin
              ep_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign err_parity_o = ep_q;
  assign err_frame_o  = ef_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: prefix decode, shift tracking,
// FWFT event FIFO and hex 7-seg history of recent make codes.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int FIFO_DEPTH     = 8,
  parameter int NUM_DIGITS     = 6,
  parameter int TIMEOUT_US     = 200,
  parameter int FILTER_LEN     = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               PS2Clk,
  input  logic                               datai,
  output logic                               key_valid,
  input  logic                               key_ready,
  output logic [7:0]                         key_code,
  output logic                               key_ext,
  output logic                               key_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               shift,
  output logic                               err_parity,
  output logic                               err_frame,
  output logic                               overflow,
  output logic [NUM_DIGITS*7-1:0]            seg
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int NH   = NUM_DIGITS / 2;
  localparam logic [6:0] INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [7:0] rx_data;
  logic       rx_valid, rx_ep, rx_ef;

  ps2_frame_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) u_frame (
    .clk_i        (clk),
    .rst_i        (rst),
    .ps2_clk_i    (PS2Clk),
    .ps2_dat_i    (datai),
    .data_o       (rx_data),
    .data_valid_o (rx_valid),
    .err_parity_o (rx_ep),
    .err_frame_o  (rx_ef)
  );

  logic       ext_q, brk_q;
  ps2_event_t ev_q;
  logic       ev_valid_q;
  logic       shl_q, shr_q;

  // Fold E0/F0 prefixes into flags; any other byte closes an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      ev_q       <= '0;
      ev_valid_q <= 1'b0;
    end else begin
      ev_valid_q <= 1'b0;
      if (rx_ep || rx_ef) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_valid) begin
        unique case (1'b1)
          (rx_data == SC_EXT):   ext_q <= 1'b1;
          (rx_data == SC_BREAK): brk_q <= 1'b1;
          default: begin
            ev_q       <= '{ext: ext_q, brk: brk_q, code: rx_data};
            ev_valid_q <= 1'b1;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  // Left/right shift state follows non-extended shift events.
  always_ff @(posedge clk) begin
    if (rst) begin
      shl_q <= 1'b0;
      shr_q <= 1'b0;
    end else if (ev_valid_q && !ev_q.ext) begin
      if (ev_q.code == SC_LSHIFT) shl_q <= !ev_q.brk;
      if (ev_q.code == SC_RSHIFT) shr_q <= !ev_q.brk;
    end
  end

  assign shift = shl_q | shr_q;

  ps2_event_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              full, empty, do_push, do_pop;
  ps2_event_t        head;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign do_pop  = key_ready && !empty;
  assign do_push = ev_valid_q && (!full || do_pop);

  // Event storage; contents only matter where the count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= ev_q;
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (ev_valid_q && full && !do_pop) ovf_q <= 1'b1;
    end
  end

  assign head       = mem_q[rd_q];
  assign key_valid  = !empty;
  assign key_code   = empty ? 8'h00 : head.code;
  assign key_ext    = !empty && head.ext;
  assign key_break  = !empty && head.brk;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign err_parity = rx_ep;
  assign err_frame  = rx_ef;

  logic [7:0] hist_q [NH];
  logic [NH-1:0] hv_q;

  // Make events push the display history up by one byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NH; i++) hist_q[i] <= '0;
      hv_q <= '0;
    end else if (ev_valid_q && !ev_q.brk) begin
      for (int i = NH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
      hist_q[0] <= ev_q.code;
      hv_q      <= {hv_q[NH-2:0], 1'b1};
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [3:0] nib;
    logic [6:0] raw;
    assign nib = (i % 2 == 1) ? hist_q[i/2][7:4] : hist_q[i/2][3:0];
    assign raw = hv_q[i/2] ? hex_to_seg(nib) : 7'h00;
    assign seg[7*i +: 7] = raw ^ INV;
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: key-event vector table
// plus hand-written error, overflow, timeout and reset sequences.
module tb_ps2_keyboard_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        PS2Clk;
  logic        datai;
  logic        key_valid;
  logic        key_ready;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_break;
  logic [3:0]  fifo_count;
  logic        shift;
  logic        err_parity;
  logic        err_frame;
  logic        overflow;
  logic [41:0] seg;

  int passed = 0;
  int total  = 0;
  int perr_cyc = 0;
  int ferr_cyc = 0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .CLK_HZ         (1_000_000),
    .FIFO_DEPTH     (8),
    .NUM_DIGITS     (6),
    .TIMEOUT_US     (200),
    .FILTER_LEN     (4),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PS2Clk     (PS2Clk),
    .datai      (datai),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .fifo_count (fifo_count),
    .shift      (shift),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow),
    .seg        (seg)
  );

  always @(negedge clk) begin
    if (err_parity === 1'b1) perr_cyc++;
    if (err_frame === 1'b1)  ferr_cyc++;
  end

  typedef struct packed {
    logic [2:0][7:0] b;
    logic [1:0]      n;
    logic [7:0]      code;
    logic            ext;
    logic            brk;
    logic            shf;
    logic [7:0]      last;
  } vec_t;

  function automatic logic [6:0] hs(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return ~t[h];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    datai = b;
    wait_clks(10);
    PS2Clk = 1'b0;
    wait_clks(10);
    PS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stop);
    datai = 1'b1;
    wait_clks(30);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1);
  endtask

  task automatic pop();
    key_ready = 1'b1;
    wait_clks(1);
    key_ready = 1'b0;
  endtask

  vec_t vecs [9];
  int   p0, f0;

  initial begin
    rst = 1'b1;
    PS2Clk = 1'b1;
    datai = 1'b1;
    key_ready = 1'b0;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2);

    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_shift", shift, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_errs", {err_parity, err_frame}, 0);
    chk("rst_seg", seg, {42{1'b1}});

    vecs[0] = '{b: {8'h00, 8'h00, 8'h1C}, n: 1, code: 8'h1C,
                ext: 0, brk: 0, shf: 0, last: 8'h1C};
    vecs[1] = '{b: {8'hE0, 8'hF0, 8'h75}, n: 3, code: 8'h75,
                ext: 1, brk: 1, shf: 0, last: 8'h1C};
    vecs[2] = '{b: {8'h00, 8'h00, 8'h12}, n: 1, code: 8'h12,
                ext: 0, brk: 0, shf: 1, last: 8'h12};
    vecs[3] = '{b: {8'h00, 8'h00, 8'h59}, n: 1, code: 8'h59,
                ext: 0, brk: 0, shf: 1, last: 8'h59};
    vecs[4] = '{b: {8'h00, 8'hF0, 8'h12}, n: 2, code: 8'h12,
                ext: 0, brk: 1, shf: 1, last: 8'h59};
    vecs[5] = '{b: {8'h00, 8'hF0, 8'h59}, n: 2, code: 8'h59,
                ext: 0, brk: 1, shf: 0, last: 8'h59};
    vecs[6] = '{b: {8'h00, 8'hE0, 8'h12}, n: 2, code: 8'h12,
                ext: 1, brk: 0, shf: 0, last: 8'h12};
    vecs[7] = '{b: {8'h00, 8'h00, 8'hE1}, n: 1, code: 8'hE1,
                ext: 0, brk: 0, shf: 0, last: 8'hE1};
    vecs[8] = '{b: {8'h00, 8'hE0, 8'h75}, n: 2, code: 8'h75,
                ext: 1, brk: 0, shf: 0, last: 8'h75};

    for (int v = 0; v < 9; v++) begin
      p0 = perr_cyc;
      f0 = ferr_cyc;
      for (int j = int'(vecs[v].n) - 1; j >= 0; j--)
        send_byte(vecs[v].b[j]);
      chk($sformatf("v%0d_count", v), fifo_count, 1);
      chk($sformatf("v%0d_valid", v), key_valid, 1);
      chk($sformatf("v%0d_code", v), key_code, vecs[v].code);
      chk($sformatf("v%0d_ext", v), key_ext, vecs[v].ext);
      chk($sformatf("v%0d_brk", v), key_break, vecs[v].brk);
      chk($sformatf("v%0d_shift", v), shift, vecs[v].shf);
      chk($sformatf("v%0d_seg", v), seg[13:0],
          {hs(vecs[v].last[7:4]), hs(vecs[v].last[3:0])});
      chk($sformatf("v%0d_noerr", v), (perr_cyc - p0) + (ferr_cyc - f0), 0);
      pop();
      chk($sformatf("v%0d_popped", v), fifo_count, 0);
    end

    chk("hist_seg", seg, {hs(4'h1), hs(4'h2), hs(4'hE),
                          hs(4'h1), hs(4'h7), hs(4'h5)});

    p0 = perr_cyc; f0 = ferr_cyc;
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("par_pulse", perr_cyc - p0, 1);
    chk("par_noframe", ferr_cyc - f0, 0);
    chk("par_count", fifo_count, 0);

    p0 = perr_cyc; f0 = ferr_cyc;
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("stop_pulse", ferr_cyc - f0, 1);
    chk("stop_nopar", perr_cyc - p0, 0);
    chk("stop_count", fifo_count, 0);

    p0 = perr_cyc; f0 = ferr_cyc;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("both_frame", ferr_cyc - f0, 1);
    chk("both_nopar", perr_cyc - p0, 0);

    send_byte(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_byte(8'h1C);
    chk("errclr_count", fifo_count, 1);
    chk("errclr_ev", {key_ext, key_break, key_code}, {2'b00, 8'h1C});
    pop();

    chk("ovf_pre", overflow, 0);
    for (int k = 1; k <= 9; k++) send_byte(8'(k));
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ovf_pop%0d", k), key_code, 8'(k));
      pop();
    end
    chk("ovf_empty", {key_valid, fifo_count}, 0);

    p0 = perr_cyc; f0 = ferr_cyc;
    ps2_bit(1'b0);
    for (int k = 0; k < 5; k++) ps2_bit(1'b1);
    datai = 1'b1;
    wait_clks(300);
    chk("to_pulse", ferr_cyc - f0, 1);
    chk("to_count", fifo_count, 0);
    send_byte(8'h29);
    chk("to_recover", {key_valid, key_code}, {1'b1, 8'h29});
    chk("to_noextra", perr_cyc - p0, 0);

    p0 = perr_cyc; f0 = ferr_cyc;
    ps2_bit(1'b0);
    for (int k = 0; k < 3; k++) ps2_bit(1'b1);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    datai = 1'b1;
    wait_clks(300);
    chk("rstmid_count", fifo_count, 0);
    chk("rstmid_noerr", (perr_cyc - p0) + (ferr_cyc - f0), 0);
    chk("rstmid_ovf", overflow, 0);
    chk("rstmid_seg", seg, {42{1'b1}});
    send_byte(8'h1C);
    chk("rstmid_next", {key_valid, key_code}, {1'b1, 8'h1C});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
